// File: rtl/store_buf_pkg.sv
// ---------------------------------------------------------------------------
// store_buf_pkg
// Shared types for the store buffer: the buffered store entry and the drain
// FSM state. Entry widths are fixed here, so store_buf and store_buf_fwd must
// be built with ADDR_W == SB_ADDR_W and DATA_W == SB_DATA_W.
// ---------------------------------------------------------------------------
package store_buf_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    // One buffered store. The address is kept word-granular because byte
    // offsets are carried by the mask.
    typedef struct packed {
        logic [SB_ADDR_W-3:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_DATA_W-1:0] mask;
    } StBufEntry_s;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } StBufState_e;

endpackage

// File: rtl/store_buf_if.sv
// ---------------------------------------------------------------------------
// store_buf_if
// Bundles the store-side push port and the memory-side req/ack drain port of
// the store buffer.
//   slave  : the store buffer (takes stores, issues memory writes)
//   master : the environment (issues stores, acknowledges memory writes)
// Signals:
//   iStEn/iStAddr/iStData/iStMask  store enable, byte address, data, mask (0 = written)
//   oStRdy                         buffer can accept a store this cycle
//   oMemReq/oMemAddr/oMemData/oMemMask  head entry write request
//   iMemAck                        memory accepted the head entry
// ---------------------------------------------------------------------------
interface store_buf_if
    import store_buf_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
);

    logic              iStEn;
    logic [ADDR_W-1:0] iStAddr;
    logic [DATA_W-1:0] iStData;
    logic [DATA_W-1:0] iStMask;
    logic              oStRdy;

    logic              oMemReq;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemData;
    logic [DATA_W-1:0] oMemMask;
    logic              iMemAck;

    modport slave (
        input  iStEn, iStAddr, iStData, iStMask, iMemAck,
        output oStRdy, oMemReq, oMemAddr, oMemData, oMemMask
    );

    modport master (
        output iStEn, iStAddr, iStData, iStMask, iMemAck,
        input  oStRdy, oMemReq, oMemAddr, oMemData, oMemMask
    );

endinterface

// File: rtl/store_buf_fwd.sv
// ---------------------------------------------------------------------------
// store_buf_fwd
// Combinational store-to-load forwarding over the store buffer entry array.
// For every byte lane, the newest valid entry whose word address matches the
// load and whose mask byte is fully written (0x00) supplies that byte.
// Only instantiated when STORE_BUF_FWD_EN is defined.
// Ports:
//   entries_i  entry storage (indexed by ring pointer)
//   headPtr_i  oldest valid entry
//   count_i    number of valid entries
//   ldAddr_i   load byte address being probed
//   fwdData_o  merged forwarded bytes (0 on lanes not supplied)
//   fwdMask_o  0 = bit supplied by the buffer
//   fwdHit_o   at least one lane supplied
// ---------------------------------------------------------------------------
module store_buf_fwd
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  StBufEntry_s              entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] headPtr_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [ADDR_W-1:0]        ldAddr_i,
    output logic [DATA_W-1:0]        fwdData_o,
    output logic [DATA_W-1:0]        fwdMask_o,
    output logic                     fwdHit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LANES = DATA_W / 8;

    logic [PTR_W-1:0] idx;
    logic             unusedLdOffset;

    assign unusedLdOffset = ^ldAddr_i[1:0];

    // Walk oldest to newest so a younger matching entry overwrites the lanes
    // supplied by an older one.
    always_comb begin
        fwdData_o = '0;
        fwdMask_o = '1;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr_i + PTR_W'(k);
            if ((k < int'(count_i)) && (entries_i[idx].addr == ldAddr_i[ADDR_W-1:2])) begin
                for (int b = 0; b < LANES; b++) begin
                    if (entries_i[idx].mask[b*8 +: 8] == 8'h00) begin
                        fwdData_o[b*8 +: 8] = entries_i[idx].data[b*8 +: 8];
                        fwdMask_o[b*8 +: 8] = 8'h00;
                    end
                end
            end
        end
    end

    assign fwdHit_o = |(~fwdMask_o);

endmodule

// File: rtl/store_buf.sv
// ---------------------------------------------------------------------------
// store_buf
// In-order store buffer between the memory-write stage and the data memory
// write port. Stores are queued as {word address, data, mask} and drained one
// per cycle over a req/ack handshake.
// Configuration macro: STORE_BUF_FWD_EN enables combinational store-to-load
// forwarding; without it the forwarding outputs are tied off (hit=0, data=0,
// mask all ones) and loads must wait for oDrained.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   sbIf        store_buf_if.slave: store push port and memory drain port
//   oEmpty      no valid entries
//   oFull       DEPTH valid entries
//   oDrained    empty and drain FSM idle (fence completion)
//   iLdAddr     load address probed for forwarding
//   oFwdHit/oFwdData/oFwdMask  forwarding result (mask 0 = supplied bit)
// ---------------------------------------------------------------------------
module store_buf
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    store_buf_if.slave        sbIf,
    output logic              oEmpty,
    output logic              oFull,
    output logic              oDrained,
    input  logic [ADDR_W-1:0] iLdAddr,
    output logic              oFwdHit,
    output logic [DATA_W-1:0] oFwdData,
    output logic [DATA_W-1:0] oFwdMask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    StBufState_e      state_q, state_d;
    StBufEntry_s      entries_q [DEPTH];
    StBufEntry_s      headEntry;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only, so a pop while full does
    // not open the buffer until the next cycle. All-ones masks write nothing.
    assign oFull       = (count_q == CNT_W'(DEPTH));
    assign oEmpty      = (count_q == '0);
    assign sbIf.oStRdy = !oFull;
    assign push        = sbIf.iStEn && !oFull && (sbIf.iStMask != '1);
    assign pop         = (state_q == REQ) && sbIf.iMemAck;
    assign oDrained    = oEmpty && (state_q == IDLE);

    // Pointer/count bookkeeping and the IDLE/REQ drain FSM.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        state_d   = state_q;

        if (push) tailPtr_d = tailPtr_q + PTR_W'(1);
        if (pop)  headPtr_d = headPtr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQ;
            REQ:     if (pop && (count_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset discards all entries and any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tailPtr_q] <= '{addr: sbIf.iStAddr[ADDR_W-1:2],
                                      data: sbIf.iStData,
                                      mask: sbIf.iStMask};
        end
    end

    // Memory outputs are gated to zero outside REQ so reset shows clean values.
    assign headEntry     = entries_q[headPtr_q];
    assign sbIf.oMemReq  = (state_q == REQ);
    assign sbIf.oMemAddr = sbIf.oMemReq ? {headEntry.addr, 2'b00} : '0;
    assign sbIf.oMemData = sbIf.oMemReq ? headEntry.data : '0;
    assign sbIf.oMemMask = sbIf.oMemReq ? headEntry.mask : '0;

`ifdef STORE_BUF_FWD_EN
    logic unusedStOffset;
    assign unusedStOffset = ^sbIf.iStAddr[1:0];

    store_buf_fwd #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uFwd (
        .entries_i (entries_q),
        .headPtr_i (headPtr_q),
        .count_i   (count_q),
        .ldAddr_i  (iLdAddr),
        .fwdData_o (oFwdData),
        .fwdMask_o (oFwdMask),
        .fwdHit_o  (oFwdHit)
    );
`else
    logic unusedStOffset;
    assign unusedStOffset = ^{sbIf.iStAddr[1:0], iLdAddr};

    assign oFwdHit  = 1'b0;
    assign oFwdData = '0;
    assign oFwdMask = '1;
`endif

    // A store presented while full is a protocol violation and is dropped.
    stEnWhileFull: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(sbIf.iStEn && oFull))
        else $warning("store_buf: store dropped, iStEn asserted while full");

endmodule

// File: tb/tb_store_buf.sv
// ---------------------------------------------------------------------------
// tb_store_buf
// Directed bench for store_buf. Every enqueued store pushes its expected
// memory write into expQ; a negedge monitor pops and compares each accepted
// memory write (oMemReq && iMemAck). Status and forwarding outputs are checked
// directly against hand-computed values.
// ---------------------------------------------------------------------------
module tb_store_buf;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } ExpWrite_t;

    logic        clk;
    logic        rst_n;
    logic        oEmpty;
    logic        oFull;
    logic        oDrained;
    logic [31:0] iLdAddr;
    logic        oFwdHit;
    logic [31:0] oFwdData;
    logic [31:0] oFwdMask;

    int          checks;
    int          failures;
    int          writeCount;
    int          wcStart;
    ExpWrite_t   expQ[$];
    ExpWrite_t   monExp;

    store_buf_if #(.ADDR_W(32), .DATA_W(32)) sbIf ();

    store_buf #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sbIf     (sbIf),
        .oEmpty   (oEmpty),
        .oFull    (oFull),
        .oDrained (oDrained),
        .iLdAddr  (iLdAddr),
        .oFwdHit  (oFwdHit),
        .oFwdData (oFwdData),
        .oFwdMask (oFwdMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value, count it, and report on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one store for one clock edge; enq says whether it should queue.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] mask, input bit enq);
        ExpWrite_t e;
        sbIf.iStEn   = 1'b1;
        sbIf.iStAddr = addr;
        sbIf.iStData = data;
        sbIf.iStMask = mask;
        if (enq) begin
            e.addr = addr & 32'hFFFF_FFFC;
            e.data = data;
            e.mask = mask;
            expQ.push_back(e);
        end
        cycle();
        sbIf.iStEn = 1'b0;
    endtask

    // Scoreboard monitor: every accepted memory write must match the oldest
    // expected entry.
    always @(negedge clk) begin
        if (rst_n && sbIf.oMemReq && sbIf.iMemAck) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedWrite: got addr 0x%08h, expected no write",
                         sbIf.oMemAddr);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("memAddr", sbIf.oMemAddr, monExp.addr);
                checkOutput("memData", sbIf.oMemData, monExp.data);
                checkOutput("memMask", sbIf.oMemMask, monExp.mask);
            end
            writeCount++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] t2Addr [4];
        logic [31:0] t2Data [4];
        t2Addr = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        t2Data = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};

        checks       = 0;
        failures     = 0;
        writeCount   = 0;
        rst_n        = 1'b0;
        sbIf.iStEn   = 1'b0;
        sbIf.iStAddr = '0;
        sbIf.iStData = '0;
        sbIf.iStMask = '1;
        sbIf.iMemAck = 1'b0;
        iLdAddr      = '0;

        // Reset state
        #2;
        checkOutput("rstMemReq",  {31'd0, sbIf.oMemReq}, 32'd0);
        checkOutput("rstStRdy",   {31'd0, sbIf.oStRdy},  32'd1);
        checkOutput("rstEmpty",   {31'd0, oEmpty},       32'd1);
        checkOutput("rstFull",    {31'd0, oFull},        32'd0);
        checkOutput("rstDrained", {31'd0, oDrained},     32'd1);
        checkOutput("rstMemAddr", sbIf.oMemAddr,         32'd0);
        checkOutput("rstMemData", sbIf.oMemData,         32'd0);
        checkOutput("rstMemMask", sbIf.oMemMask,         32'd0);
        checkOutput("rstFwdHit",  {31'd0, oFwdHit},      32'd0);
        checkOutput("rstFwdMask", oFwdMask,              32'hFFFF_FFFF);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("[TB] test 1: single push and drain");
        applyStimulus(32'h0000_0100, 32'h0000_00AB, 32'hFFFF_FF00, 1'b1);
        checkOutput("t1ReqAtK",  {31'd0, sbIf.oMemReq}, 32'd0);
        checkOutput("t1EmptyK",  {31'd0, oEmpty},       32'd0);
        cycle();
        checkOutput("t1ReqK1",   {31'd0, sbIf.oMemReq}, 32'd1);
        checkOutput("t1MemAddr", sbIf.oMemAddr,         32'h0000_0100);
        checkOutput("t1MemData", sbIf.oMemData,         32'h0000_00AB);
        checkOutput("t1MemMask", sbIf.oMemMask,         32'hFFFF_FF00);
        sbIf.iMemAck = 1'b1;
        cycle();
        sbIf.iMemAck = 1'b0;
        checkOutput("t1Drained", {31'd0, oDrained},     32'd1);
        checkOutput("t1ReqOff",  {31'd0, sbIf.oMemReq}, 32'd0);

        $display("[TB] test 2: fill, overflow attempt, back-to-back drain");
        for (int i = 0; i < 4; i++) applyStimulus(t2Addr[i], t2Data[i], 32'h0, 1'b1);
        checkOutput("t2Full",  {31'd0, oFull},       32'd1);
        checkOutput("t2StRdy", {31'd0, sbIf.oStRdy}, 32'd0);
        applyStimulus(32'h0000_2000, 32'h0000_DEAD, 32'h0, 1'b0);
        checkOutput("t2FullAfterDrop", {31'd0, oFull}, 32'd1);
        wcStart      = writeCount;
        sbIf.iMemAck = 1'b1;
        repeat (4) cycle();
        sbIf.iMemAck = 1'b0;
        checkOutput("t2WriteCount", writeCount - wcStart, 32'd4);
        checkOutput("t2Empty",      {31'd0, oEmpty},      32'd1);
        checkOutput("t2ReqOff",     {31'd0, sbIf.oMemReq}, 32'd0);

        $display("[TB] test 3: simultaneous push and pop with pointer wrap");
        applyStimulus(32'h0000_3000, 32'h3333_0000, 32'h0, 1'b1);
        applyStimulus(32'h0000_3004, 32'h3333_0001, 32'h0, 1'b1);
        applyStimulus(32'h0000_3008, 32'h3333_0002, 32'h0, 1'b1);
        wcStart      = writeCount;
        sbIf.iMemAck = 1'b1;
        applyStimulus(32'h0000_300C, 32'h3333_0003, 32'h0, 1'b1);
        sbIf.iMemAck = 1'b0;
        checkOutput("t3FullAfterPushPop", {31'd0, oFull}, 32'd0);
        applyStimulus(32'h0000_3010, 32'h3333_0004, 32'h0, 1'b1);
        checkOutput("t3FullAtFour", {31'd0, oFull}, 32'd1);
        sbIf.iMemAck = 1'b1;
        repeat (4) cycle();
        sbIf.iMemAck = 1'b0;
        checkOutput("t3WriteCount", writeCount - wcStart, 32'd5);
        checkOutput("t3Empty",      {31'd0, oEmpty},      32'd1);

        $display("[TB] test 4: all-ones mask is not enqueued");
        applyStimulus(32'h0000_0400, 32'h0000_0055, 32'hFFFF_FFFF, 1'b0);
        checkOutput("t4Empty", {31'd0, oEmpty}, 32'd1);
        cycle();
        checkOutput("t4ReqOff",  {31'd0, sbIf.oMemReq}, 32'd0);
        checkOutput("t4Drained", {31'd0, oDrained},     32'd1);

        $display("[TB] test 5: reset mid-drain");
        applyStimulus(32'h0000_0500, 32'h5555_0000, 32'h0, 1'b1);
        applyStimulus(32'h0000_0504, 32'h5555_0001, 32'h0, 1'b1);
        applyStimulus(32'h0000_0508, 32'h5555_0002, 32'h0, 1'b1);
        checkOutput("t5ReqBefore", {31'd0, sbIf.oMemReq}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5ReqInRst",     {31'd0, sbIf.oMemReq}, 32'd0);
        checkOutput("t5EmptyInRst",   {31'd0, oEmpty},       32'd1);
        checkOutput("t5StRdyInRst",   {31'd0, sbIf.oStRdy},  32'd1);
        checkOutput("t5MemAddrInRst", sbIf.oMemAddr,         32'd0);
        expQ.delete();
        wcStart      = writeCount;
        sbIf.iMemAck = 1'b1;
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        sbIf.iMemAck = 1'b0;
        checkOutput("t5EmptyAfter",  {31'd0, oEmpty},       32'd1);
        checkOutput("t5ReqAfter",    {31'd0, sbIf.oMemReq}, 32'd0);
        checkOutput("t5NoStaleWr",   writeCount - wcStart,  32'd0);

        $display("[TB] test 6: store-to-load forwarding probe");
        applyStimulus(32'h0000_0200, 32'h0000_0011, 32'hFFFF_FF00, 1'b1);
        applyStimulus(32'h0000_0200, 32'h0000_0022, 32'hFFFF_FF00, 1'b1);
        applyStimulus(32'h0000_0202, 32'h3344_0000, 32'h0000_FFFF, 1'b1);
        iLdAddr = 32'h0000_0200;
        #1;
`ifdef STORE_BUF_FWD_EN
        checkOutput("t6FwdHit",  {31'd0, oFwdHit}, 32'd1);
        checkOutput("t6FwdData", oFwdData,         32'h3344_0022);
        checkOutput("t6FwdMask", oFwdMask,         32'h0000_FF00);
`else
        checkOutput("t6FwdHit",  {31'd0, oFwdHit}, 32'd0);
        checkOutput("t6FwdData", oFwdData,         32'h0);
        checkOutput("t6FwdMask", oFwdMask,         32'hFFFF_FFFF);
`endif
        iLdAddr = 32'h0000_0204;
        #1;
        checkOutput("t6MissHit",  {31'd0, oFwdHit}, 32'd0);
        checkOutput("t6MissMask", oFwdMask,         32'hFFFF_FFFF);
        wcStart      = writeCount;
        sbIf.iMemAck = 1'b1;
        repeat (3) cycle();
        sbIf.iMemAck = 1'b0;
        checkOutput("t6WriteCount", writeCount - wcStart, 32'd3);
        checkOutput("t6Drained",    {31'd0, oDrained},    32'd1);

        cycle();
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
